// File: rtl/cmd_regfile_if.sv
// cmd_regfile_if: command and transmit handshake bundle for cmd_regfile.
//   cmd_en    one-cycle command strobe from the UART command receiver
//   cmd_addr  command address (bit 7 set = read request)
//   cmd_data  command write data
//   tx_data   byte offered to the UART transmitter
//   tx_start  one-cycle transmit request
//   tx_busy   transmitter busy
// Modports: slave = cmd_regfile, master = the receiver/transmitter environment.
interface cmd_regfile_if;
    logic        cmd_en;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;

    modport master (
        output cmd_en, cmd_addr, cmd_data, tx_busy,
        input  tx_data, tx_start
    );

    modport slave (
        input  cmd_en, cmd_addr, cmd_data, tx_busy,
        output tx_data, tx_start
    );
endinterface

// File: rtl/cmd_regfile.sv
// cmd_regfile: bank of 16-bit control registers written and read by UART commands.
// Writes apply on the command edge and pulse wr_strobe one cycle later. Reads are
// queued (one response in progress plus one pending) and answered as a byte frame:
// address echo, data low byte, data high byte.
// Ports:
//   i_clk       system clock (rising edge)
//   rst         asynchronous active-low reset
//   bus         cmd_regfile_if.slave: command input and transmitter handshake
//   regs_flat   all registers, register n at bits [16n+15:16n]
//   wr_strobe   one-cycle pulse after each accepted write
//   wr_index    index of the last accepted write
//   rd_overrun  sticky: a read request was dropped (cleared by a write to address 0)
// Build option: define CMD_REGFILE_CHECKSUM_EN to append a checksum byte
// (addr ^ data[7:0] ^ data[15:8]) to every response frame.
module cmd_regfile #(
    parameter int unsigned NUM_REGS = 16,
    parameter logic [15:0] ID_VALUE = 16'hA5C3
) (
    input  logic                        i_clk,
    input  logic                        rst,
    cmd_regfile_if.slave                bus,
    output logic [NUM_REGS*16-1:0]      regs_flat,
    output logic                        wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0] wr_index,
    output logic                        rd_overrun
);
    localparam int unsigned IdxW     = $clog2(NUM_REGS);
    localparam logic [7:0]  NumRegsB = 8'(NUM_REGS);
`ifdef CMD_REGFILE_CHECKSUM_EN
    localparam logic [1:0]  LastByte = 2'd3;
`else
    localparam logic [1:0]  LastByte = 2'd2;
`endif

    typedef enum logic [1:0] {TxIdle, TxSend, TxWaitHi, TxWaitLo} tx_state_e;

    tx_state_e   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  frame_addr_q, frame_addr_d;
    logic [15:0] frame_data_q, frame_data_d;
    logic        head_vld_q, head_vld_d, slot_vld_q, slot_vld_d;
    logic [7:0]  head_addr_q, head_addr_d, slot_addr_q, slot_addr_d;
    logic        wr_strobe_q;
    logic [IdxW-1:0] wr_index_q, wr_idx, head_idx;
    logic        overrun_q, overrun_d;
    logic [15:0] regs_q [NUM_REGS-1:1];
    logic [15:0] regs_view [NUM_REGS];

    logic is_wr, is_rd, wr_in_range, head_in_range;
    logic wr_apply, ovr_clr, rd_accept, rd_drop, rsp_done, tx_start;
    logic [7:0] tx_byte;

    // Command decode
    assign is_wr         = bus.cmd_en & ~bus.cmd_addr[7];
    assign is_rd         = bus.cmd_en & bus.cmd_addr[7];
    assign wr_idx        = bus.cmd_addr[IdxW-1:0];
    assign wr_in_range   = {1'b0, bus.cmd_addr[6:0]} < NumRegsB;
    assign wr_apply      = is_wr & wr_in_range & (wr_idx != '0);
    assign ovr_clr       = is_wr & (bus.cmd_addr[6:0] == 7'd0);
    // A read is taken when the pending slot is free, or frees up on this very edge.
    assign rd_accept     = is_rd & (~slot_vld_q | rsp_done);
    assign rd_drop       = is_rd & ~rd_accept;

    assign head_idx      = head_addr_q[IdxW-1:0];
    assign head_in_range = {1'b0, head_addr_q[6:0]} < NumRegsB;

    // Register 0 is the constant ID; the others are state.
    always_comb begin
        regs_view[0] = ID_VALUE;
        for (int unsigned n = 1; n < NUM_REGS; n++) begin
            regs_view[n] = regs_q[n];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*16 +: 16] = regs_view[g];
    end

    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned n = 1; n < NUM_REGS; n++) begin
                regs_q[n] <= '0;
            end
        end else begin
            for (int unsigned n = 1; n < NUM_REGS; n++) begin
                if (wr_apply && (wr_idx == IdxW'(n))) begin
                    regs_q[n] <= bus.cmd_data;
                end
            end
        end
    end

    // Read queue: head is the request being (or about to be) answered, slot is the
    // one waiting behind it. The head is popped only when its last byte completes.
    always_comb begin
        head_vld_d  = head_vld_q;
        head_addr_d = head_addr_q;
        slot_vld_d  = slot_vld_q;
        slot_addr_d = slot_addr_q;
        if (rsp_done) begin
            head_vld_d  = slot_vld_q;
            head_addr_d = slot_addr_q;
            slot_vld_d  = 1'b0;
        end
        if (rd_accept) begin
            if (!head_vld_d) begin
                head_vld_d  = 1'b1;
                head_addr_d = bus.cmd_addr;
            end else begin
                slot_vld_d  = 1'b1;
                slot_addr_d = bus.cmd_addr;
            end
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end else if (rd_drop) begin
            overrun_d = 1'b1;
        end
    end

    // Transmit FSM
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frame_addr_d = frame_addr_q;
        frame_data_d = frame_data_q;
        tx_start     = 1'b0;
        rsp_done     = 1'b0;
        case (state_q)
            TxIdle: begin
                if (head_vld_q && !bus.tx_busy) begin
                    // Data is sampled here, so a write still in flight is reflected.
                    frame_addr_d = head_addr_q;
                    frame_data_d = head_in_range ? regs_view[head_idx] : 16'h0000;
                    cnt_d        = 2'd0;
                    state_d      = TxSend;
                end
            end
            TxSend: begin
                if (!bus.tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = TxWaitHi;
                end
            end
            TxWaitHi: begin
                if (bus.tx_busy) begin
                    state_d = TxWaitLo;
                end
            end
            TxWaitLo: begin
                if (!bus.tx_busy) begin
                    if (cnt_q == LastByte) begin
                        rsp_done = 1'b1;
                        state_d  = TxIdle;
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                        state_d = TxSend;
                    end
                end
            end
            default: state_d = TxIdle;
        endcase
    end

    // Byte select; frame registers and counter only change on entry to TxSend,
    // so the byte is held until the next send.
    always_comb begin
        case (cnt_q)
            2'd0:    tx_byte = frame_addr_q;
            2'd1:    tx_byte = frame_data_q[7:0];
            2'd2:    tx_byte = frame_data_q[15:8];
`ifdef CMD_REGFILE_CHECKSUM_EN
            default: tx_byte = frame_addr_q ^ frame_data_q[7:0] ^ frame_data_q[15:8];
`else
            default: tx_byte = 8'h00;
`endif
        endcase
    end

    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= TxIdle;
            cnt_q        <= 2'd0;
            frame_addr_q <= 8'h00;
            frame_data_q <= 16'h0000;
            head_vld_q   <= 1'b0;
            head_addr_q  <= 8'h00;
            slot_vld_q   <= 1'b0;
            slot_addr_q  <= 8'h00;
            wr_strobe_q  <= 1'b0;
            wr_index_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frame_addr_q <= frame_addr_d;
            frame_data_q <= frame_data_d;
            head_vld_q   <= head_vld_d;
            head_addr_q  <= head_addr_d;
            slot_vld_q   <= slot_vld_d;
            slot_addr_q  <= slot_addr_d;
            wr_strobe_q  <= wr_apply;
            if (wr_apply) begin
                wr_index_q <= wr_idx;
            end
            overrun_q    <= overrun_d;
        end
    end

    assign wr_strobe    = wr_strobe_q;
    assign wr_index     = wr_index_q;
    assign rd_overrun   = overrun_q;
    assign bus.tx_data  = tx_byte;
    assign bus.tx_start = tx_start;
endmodule

// File: tb/tb_cmd_regfile.sv
`timescale 1ns/1ps
module tb_cmd_regfile;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned W        = NUM_REGS * 16;
    localparam logic [15:0] ID_VALUE = 16'hA5C3;
`ifdef CMD_REGFILE_CHECKSUM_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmd_regfile_if bus();
    logic [W-1:0]                  regs_flat;
    logic                          wr_strobe;
    logic [$clog2(NUM_REGS)-1:0]   wr_index;
    logic                          rd_overrun;
    logic                          busy_drv = 1'b0;
    logic                          hold_busy = 1'b0;

    assign bus.tx_busy = busy_drv | hold_busy;

    cmd_regfile #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)) dut (
        .i_clk      (clk),
        .rst        (rst_n),
        .bus        (bus),
        .regs_flat  (regs_flat),
        .wr_strobe  (wr_strobe),
        .wr_index   (wr_index),
        .rd_overrun (rd_overrun)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_tx     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [W-1:0] act,
                                  input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    // Reference model
    logic [15:0] m_regs [NUM_REGS];
    bit          m_ovr;
    logic [7:0]  exp_q [$];
    typedef struct { int idx; logic [15:0] data; int cyc; } wr_exp_t;
    wr_exp_t     wr_exp_q [$];
    wr_exp_t     mon_e;

    function automatic void model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 16'h0000;
        m_ovr = 1'b0;
    endfunction

    function automatic logic [15:0] m_read(input logic [7:0] a);
        int idx = int'(a[6:0]);
        if (idx >= NUM_REGS) return 16'h0000;
        if (idx == 0) return ID_VALUE;
        return m_regs[idx];
    endfunction

    function automatic logic [W-1:0] model_flat();
        logic [W-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i*16 +: 16] = (i == 0) ? ID_VALUE : m_regs[i];
        return v;
    endfunction

    function automatic void push_frame(input logic [7:0] a);
        logic [15:0] d = m_read(a);
        exp_q.push_back(a);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(d[15:8]);
`ifdef CMD_REGFILE_CHECKSUM_EN
        exp_q.push_back(a ^ d[7:0] ^ d[15:8]);
`endif
    endfunction

    // Transmitter model plus response monitor
    initial begin : tx_model
        forever begin
            @(negedge clk);
            if (rst_n && bus.tx_start) begin
                n_tx++;
                check("tx_start_while_busy", W'(bus.tx_busy), W'(0));
                if (exp_q.size() == 0) check("tx_unexpected_byte", W'(bus.tx_data), W'(9'h100));
                else check("tx_byte", W'(bus.tx_data), W'(exp_q.pop_front()));
                @(posedge clk);
                #1 busy_drv = 1'b1;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 busy_drv = 1'b0;
            end
        end
    end

    // Write-strobe monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_exp_q.size() != 0 && wr_exp_q[0].cyc <= cyc) begin
                mon_e = wr_exp_q.pop_front();
                check("wr_strobe", W'(wr_strobe), W'(1));
                check("wr_index", W'(wr_index), W'(mon_e.idx));
                check("wr_reg_value", W'(regs_flat[mon_e.idx*16 +: 16]), W'(mon_e.data));
            end else if (wr_strobe) begin
                check("wr_strobe_spurious", W'(wr_strobe), W'(0));
            end
        end
    end

    // Drives one command cycle; called at posedge+1, returns at posedge+1.
    task automatic issue(input logic [7:0] a, input logic [15:0] d,
                         input bit rd_ok, input bit push_rsp);
        int idx;
        bus.cmd_en = 1'b1;
        bus.cmd_addr = a;
        bus.cmd_data = d;
        @(posedge clk); #1;
        bus.cmd_en = 1'b0;
        if (a[7]) begin
            if (!rd_ok) m_ovr = 1'b1;
            else if (push_rsp) push_frame(a);
        end else begin
            idx = int'(a[6:0]);
            if (idx == 0) m_ovr = 1'b0;
            else if (idx < NUM_REGS) begin
                m_regs[idx] = d;
                wr_exp_q.push_back('{idx, d, cyc});
            end
        end
    endtask

    task automatic drain(input string name);
        int i = 0;
        while (exp_q.size() != 0 && i < 3000) begin
            @(posedge clk);
            i++;
        end
        check(name, W'(exp_q.size()), W'(0));
        exp_q.delete();
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_regs"}, regs_flat, model_flat());
        check({tag, "_overrun"}, W'(rd_overrun), W'(m_ovr));
    endtask

    initial begin
        int nw, nr, base;
        logic [7:0] a;
        bus.cmd_en = 1'b0;
        bus.cmd_addr = 8'h00;
        bus.cmd_data = 16'h0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_regs", regs_flat, model_flat());
        check("rst_wr_strobe", W'(wr_strobe), W'(0));
        check("rst_wr_index", W'(wr_index), W'(0));
        check("rst_tx_start", W'(bus.tx_start), W'(0));
        check("rst_tx_data", W'(bus.tx_data), W'(0));
        check("rst_overrun", W'(rd_overrun), W'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ID read, write/readback, ignored writes
        issue(8'h80, 16'h0000, 1'b1, 1'b1);
        drain("drain_id");
        check_state("id");
        issue(8'h05, 16'h1234, 1'b0, 1'b0);
        issue(8'h85, 16'h0000, 1'b1, 1'b1);
        drain("drain_r5");
        issue(8'h00, 16'hFFFF, 1'b0, 1'b0);
        issue(8'h20, 16'hDEAD, 1'b0, 1'b0);
        repeat (2) @(posedge clk); #1;
        check_state("ignored_wr");

        // Overrun with the transmitter held busy
        issue(8'h01, 16'h1111, 1'b0, 1'b0);
        issue(8'h02, 16'h2222, 1'b0, 1'b0);
        issue(8'h03, 16'h3333, 1'b0, 1'b0);
        hold_busy = 1'b1;
        issue(8'h81, 16'h0000, 1'b1, 1'b1);
        issue(8'h82, 16'h0000, 1'b1, 1'b1);
        issue(8'h83, 16'h0000, 1'b0, 1'b0);
        check("overrun_set", W'(rd_overrun), W'(1));
        repeat (5) @(posedge clk); #1;
        hold_busy = 1'b0;
        drain("drain_overrun");
        check_state("after_overrun");
        issue(8'h00, 16'h0000, 1'b0, 1'b0);
        check("overrun_clr", W'(rd_overrun), W'(0));

        // Data is taken at response start, after a write queued behind the read
        hold_busy = 1'b1;
        issue(8'h84, 16'h0000, 1'b1, 1'b0);
        issue(8'h04, 16'hBEEF, 1'b0, 1'b0);
        push_frame(8'h84);
        repeat (3) @(posedge clk); #1;
        hold_busy = 1'b0;
        drain("drain_late_wr");

        // Checksum pattern (frame has 3 or 4 bytes depending on build)
        issue(8'h03, 16'h00FF, 1'b0, 1'b0);
        issue(8'h83, 16'h0000, 1'b1, 1'b1);
        drain("drain_r3");

        // Randomised bursts
        for (int it = 0; it < 25; it++) begin
            nw = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++) begin
                a = 8'($urandom_range(0, 31));
                issue(a, 16'($urandom), 1'b0, 1'b0);
            end
            nr = $urandom_range(1, 3);
            for (int k = 0; k < nr; k++) begin
                a = 8'h80 | 8'($urandom_range(0, 31));
                issue(a, 16'h0000, k < 2, 1'b1);
            end
            drain("drain_rand");
            check_state("rand");
        end

        // Reset after the first byte of a response
        issue(8'h0A, 16'hCAFE, 1'b0, 1'b0);
        issue(8'h8A, 16'h0000, 1'b1, 1'b1);
        begin
            int i = 0;
            while (exp_q.size() > FRAME_LEN - 1 && i < 500) begin
                @(posedge clk);
                i++;
            end
            check("first_byte_seen", W'(exp_q.size()), W'(FRAME_LEN - 1));
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        exp_q.delete();
        wr_exp_q.delete();
        check("midrst_regs", regs_flat, model_flat());
        check("midrst_tx_start", W'(bus.tx_start), W'(0));
        check("midrst_tx_data", W'(bus.tx_data), W'(0));
        check("midrst_wr_strobe", W'(wr_strobe), W'(0));
        check("midrst_wr_index", W'(wr_index), W'(0));
        check("midrst_overrun", W'(rd_overrun), W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        base = n_tx;
        repeat (60) @(posedge clk); #1;
        check("no_tx_after_rst", W'(n_tx - base), W'(0));
        issue(8'h80, 16'h0000, 1'b1, 1'b1);
        drain("drain_after_rst");

        check("wr_exp_empty", W'(wr_exp_q.size()), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cmd_regfile.md
Name: cmd_regfile

Overview:
- Sits directly downstream of the UART command receiver.
- Consumes each one-cycle command pulse (8-bit address, 16-bit data) and applies it to a bank of 16-bit control registers that drive the rest of the design.
- Read commands are answered over a byte-wide UART transmitter handshake, which returns the register contents to the host.
- Single clock domain.

Parameters:
- NUM_REGS, 16: number of 16-bit registers. Power of two, 2..128.
- ID_VALUE, 16'hA5C3: constant value returned by register 0. Register 0 is read-only.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_en  in  1  one-cycle command strobe.
- cmd_addr  in  8  command address; qualified by cmd_en.
- cmd_data  in  16  command data; qualified by cmd_en.
- regs_flat  out  NUM_REGS*16  all registers; register n occupies bits [16n+15:16n].
- wr_strobe  out  1  one-cycle pulse after each accepted write.
- wr_index  out  $clog2(NUM_REGS)  index of the last accepted write.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle transmit request.
- tx_busy  in  1  transmitter busy.
- rd_overrun  out  1  sticky flag: a read command was dropped.

Behaviour:
- Reset (rst=0, async) drives:
  - all registers 1..NUM_REGS-1 to 0; register 0 always reads ID_VALUE;
  - wr_strobe=0, wr_index=0, tx_start=0, tx_data=0, rd_overrun=0;
  - FSM to TX_IDLE, pending-read slot empty.
- Reset mid-response abandons the response. No further tx_start until a new read arrives.
- Command decode on a cmd_en cycle: idx = cmd_addr[$clog2(NUM_REGS)-1:0].
  - cmd_addr[7]=0 → write.
    - Out-of-range addresses (cmd_addr[6:0] >= NUM_REGS) are ignored: no strobe.
    - idx 0 is ignored, except as a clear: a write to address 0 clears rd_overrun. No strobe.
    - Otherwise the register updates on the same edge. wr_strobe=1 and wr_index=idx on the following cycle (latency 1).
  - cmd_addr[7]=1 → read request for idx (bit 6 ignored; out-of-range reads return 16'h0000).
- Read queueing:
  - One pending slot holding the address, plus the response in flight.
  - Read data is sampled when the response starts, not when the request arrives.
  - A read arriving while the slot is full is dropped and sets rd_overrun.
  - Writes are never blocked by reads.
  - A read and a write to the same register in flight: the response carries the value present at response start.
- Response frame, in order: echo of cmd_addr, data[7:0], data[15:8]. Low byte first, matching the receiver's byte order.
- TX FSM:
  - TX_IDLE: slot full and tx_busy=0 → latch frame, byte counter = 0, go to TX_SEND.
  - TX_SEND: tx_start=1 for exactly one cycle with tx_data valid (tx_data held until the next TX_SEND) → TX_WAIT_HI.
  - TX_WAIT_HI: wait for tx_busy=1 → TX_WAIT_LO.
  - TX_WAIT_LO: wait for tx_busy=0, then:
    - more bytes → increment counter, TX_SEND;
    - last byte → TX_IDLE, slot released.
  - Slot release and a new read in the same cycle: the new read is accepted, not dropped.
- tx_start is never asserted while tx_busy=1.
- No timeout: a stuck tx_busy stalls responses indefinitely. Writes continue regardless.

Optional Feature:
- Macro: CMD_REGFILE_CHECKSUM_EN.
- Defined: a 4th byte is appended to every response, equal to addr ^ data[7:0] ^ data[15:8]; byte counter range 0..3.
- Undefined: 3-byte frame, no checksum logic.

Test Plan:
- Reset, then read 0x80 → tx bytes 0x80, 0xC3, 0xA5. All regs 1..15 = 0. rd_overrun=0.
- Write addr 0x05 data 0x1234 → regs_flat[95:80]=0x1234 on the next edge. One wr_strobe pulse with wr_index=5. Read 0x85 → bytes 0x85, 0x34, 0x12.
- Write addr 0x00 data 0xFFFF → register 0 still 0xA5C3, no wr_strobe. Write addr 0x20 (out of range) → no change, no strobe.
- Three reads 0x81, 0x82, 0x83 back-to-back while tx_busy is held high → 0x81 and 0x82 answered in order, 0x83 dropped, rd_overrun=1. Write addr 0x00 → rd_overrun=0.
- Assert rst after the first byte of a response → outputs return to reset values immediately. No further tx_start.
- With CMD_REGFILE_CHECKSUM_EN, reg 3 = 0x00FF, read 0x83 → bytes 0x83, 0xFF, 0x00, 0x7C.
